// File: rtl/mac_sequencer.sv
// Drives an accumulate-capable MAC: INIT (load bias), K accepted operand pairs, CAP (capture result).
// Result is registered one cycle after CAP; in_ready stays low in CAP while the previous result is unconsumed.
module mac_sequencer #(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int K    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  in_a,
  input  logic [INW-1:0]  in_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [INW-1:0]  bias,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic [INW-1:0]  mac_init_value,
  output logic            mac_init_acc,
  output logic            mac_input_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    ACC  = 2'd1,
    CAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cap_load;

  assign mac_in0         = in_a;
  assign mac_in1         = in_b;
  assign mac_init_value  = bias;
  assign mac_input_valid = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    in_ready     = 1'b0;
    mac_init_acc = 1'b0;
    cap_load     = 1'b0;
    case (state)
      INIT: begin
        mac_init_acc = 1'b1;
        cnt_nxt      = '0;
        state_nxt    = ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = CAP;
        end
      end
      CAP: begin
        // MAC accumulator already holds the final sum here (1-cycle update latency)
        if (!out_valid || out_ready) begin
          cap_load  = 1'b1;
          state_nxt = INIT;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (cap_load) begin
      out_valid <= 1'b1;
      out_data  <= mac_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC, queue-based result model, vector table, directed and random phases.
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // K=4 instance
  logic [15:0] in_a, in_b, bias, mac_in0, mac_in1, mac_init_value;
  logic        in_valid, in_ready, mac_init_acc, mac_input_valid, out_valid, out_ready;
  logic [63:0] mac_out, out_data;

  // K=1 instance
  logic [15:0] k1_a, k1_b, k1_bias, k1_m0, k1_m1, k1_miv_val;
  logic        k1_valid, k1_ready, k1_init, k1_miv, k1_out_valid, k1_out_ready;
  logic [63:0] k1_mac_out, k1_out_data;

  mac_sequencer #(.INW(16), .OUTW(64), .K(4)) u_dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .bias(bias), .mac_in0(mac_in0), .mac_in1(mac_in1), .mac_init_value(mac_init_value),
    .mac_init_acc(mac_init_acc), .mac_input_valid(mac_input_valid), .mac_out(mac_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  mac_sequencer #(.INW(16), .OUTW(64), .K(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_a(k1_a), .in_b(k1_b), .in_valid(k1_valid), .in_ready(k1_ready),
    .bias(k1_bias), .mac_in0(k1_m0), .mac_in1(k1_m1), .mac_init_value(k1_miv_val),
    .mac_init_acc(k1_init), .mac_input_valid(k1_miv), .mac_out(k1_mac_out),
    .out_data(k1_out_data), .out_valid(k1_out_valid), .out_ready(k1_out_ready)
  );

  function automatic longint prod(input logic [15:0] x, input logic [15:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return sx * sy;
  endfunction

  // Behavioural MACs: registered accumulator, init has priority
  logic [63:0] acc4, acc1;
  always @(posedge clk or posedge reset) begin
    if (reset) acc4 <= '0;
    else if (mac_init_acc) acc4 <= longint'($signed(mac_init_value));
    else if (mac_input_valid) acc4 <= acc4 + prod(mac_in0, mac_in1);
  end
  always @(posedge clk or posedge reset) begin
    if (reset) acc1 <= '0;
    else if (k1_init) acc1 <= longint'($signed(k1_miv_val));
    else if (k1_miv) acc1 <= acc1 + prod(k1_m0, k1_m1);
  end
  assign mac_out    = acc4;
  assign k1_mac_out = acc1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, ex);
    end
  endtask

  // Reference model: collect accepted products, every 4 form bias + sum, expect results in order
  longint      part[$];
  longint      exp_q[$];
  longint      msum;
  int          miv_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [63:0] hold_data;

  always @(negedge clk) begin
    #2;
    if (reset) begin
      part.delete();
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("strobe_exclusive", longint'(mac_init_acc & mac_input_valid), 0);
      chk("passthrough", longint'({mac_in0, mac_in1, mac_init_value} == {in_a, in_b, bias}), 1);
      chk("accept_strobe", longint'(mac_input_valid), longint'(in_valid & in_ready));
      if (mac_input_valid) miv_cnt++;
      if (hold_prev) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_data", out_data, hold_data);
      end
      if (in_valid && in_ready) begin
        part.push_back(prod(in_a, in_b));
        if (part.size() == 4) begin
          msum = longint'($signed(bias));
          foreach (part[i]) msum += part[i];
          exp_q.push_back(msum);
          part.delete();
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("model_data", out_data, exp_q.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  typedef struct packed {
    logic [15:0]      bias;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [7:0]       vmask;
    logic [63:0]      ex;
    logic [7:0]       lat;
  } vec_t;

  function automatic vec_t mk(input int bs, input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3,
                              input logic [7:0] vm, input longint ex, input int lat);
    vec_t v;
    v.bias  = 16'(bs);
    v.a     = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    v.b     = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    v.vmask = vm;
    v.ex    = ex;
    v.lat   = 8'(lat);
    return v;
  endfunction

  task automatic do_reset(input logic [15:0] b);
    @(negedge clk);
    reset = 1'b1;
    bias  = b;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered at a falling edge; returns at the falling edge after the pair was accepted
  task automatic send(input int a, input int b);
    int   tries;
    logic ok;
    tries    = 0;
    in_valid = 1'b1;
    in_a     = 16'(a);
    in_b     = 16'(b);
    do begin
      #1;
      ok = in_ready;
      @(negedge clk);
      tries++;
    end while (!ok && tries < 40);
    if (!ok) chk("send_timeout", 1, 0);
  endtask

  task automatic wait_out(output logic [63:0] d);
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("out_timeout", longint'(out_valid), 1);
    d = out_data;
  endtask

  task automatic run_vec(input vec_t v);
    int          idx, lat_seen;
    logic        cap_next;
    logic [63:0] d;
    out_ready = 1'b1;
    do_reset(v.bias);
    miv_cnt  = 0;
    idx      = 0;
    lat_seen = -1;
    cap_next = 1'b0;
    d        = '0;
    in_valid = 1'b1;
    in_a     = v.a[0];
    in_b     = v.b[0];
    #1;
    chk("init_in_ready", longint'(in_ready), 0);
    chk("init_strobe", longint'(mac_init_acc), 1);
    for (int n = 1; n <= 30 && lat_seen < 0; n++) begin
      @(negedge clk);
      if (cap_next) begin
        chk("cap_in_ready", longint'(in_ready), 0);
        chk("cap_no_strobe", longint'(mac_input_valid), 0);
        cap_next = 1'b0;
      end
      if (out_valid) begin
        lat_seen = n;
        d        = out_data;
        chk("next_init_same_cycle", longint'(mac_init_acc), 1);
      end
      in_valid = (idx < 4) && ((n <= 8) ? v.vmask[n-1] : 1'b1);
      if (idx < 4) begin
        in_a = v.a[idx];
        in_b = v.b[idx];
      end
      #1;
      if (in_valid && in_ready) begin
        idx++;
        if (idx == 4) cap_next = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("vec_latency", lat_seen, longint'(v.lat));
    chk("vec_data", d, v.ex);
    chk("vec_strobe_count", miv_cnt, 4);
  endtask

  vec_t        tbl[7];
  logic [63:0] rd;
  int          k1_cnt, k1_first, t;

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b1;
    in_a         = '0;
    in_b         = '0;
    bias         = '0;
    out_ready    = 1'b1;
    k1_valid     = 1'b0;
    k1_a         = 16'd4;
    k1_b         = 16'd5;
    k1_bias      = 16'd3;
    k1_out_ready = 1'b1;
    #2;
    chk("por_out_valid", longint'(out_valid), 0);
    chk("por_out_data", out_data, 0);
    chk("por_in_ready", longint'(in_ready), 0);
    chk("por_strobe", longint'(mac_input_valid), 0);
    chk("por_init", longint'(mac_init_acc), 1);
    in_valid = 1'b0;

    tbl[0] = mk(5, 1, 2, 3, 4, 1, 1, 1, 1, 8'hFF, 64'sd15, 6);
    tbl[1] = mk(-10, -3, -3, -3, -3, 7, 7, 7, 7, 8'hFF, -64'sd94, 6);
    tbl[2] = mk(0, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 8'hFF, 64'sd4294967296, 6);
    tbl[3] = mk(5, 1, 2, 3, 4, 1, 1, 1, 1, 8'b1101_1001, 64'sd15, 9);
    tbl[4] = mk(0, 1, 1, 1, 1, 2, 2, 2, 2, 8'hFF, 64'sd8, 6);
    tbl[5] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 8'hFF, 64'sd4294737923, 6);
    tbl[6] = mk(-32768, 100, -200, 300, -400, -5, 6, -7, 8, 8'hFF, -64'sd39768, 6);
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Backpressure across two back-to-back vectors
    out_ready = 1'b0;
    do_reset(16'd5);
    send(1, 1); send(2, 1); send(3, 1); send(4, 1);
    send(5, 1); send(5, 1); send(5, 1); send(10, 1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_stall_in_ready", longint'(in_ready), 0);
    chk("bp_first_valid", longint'(out_valid), 1);
    chk("bp_first_data", out_data, 15);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", longint'(out_valid), 1);
    chk("bp_second_data", out_data, 30);
    @(negedge clk);
    chk("bp_drained", longint'(out_valid), 0);

    // Reset in the middle of a vector with a result pending
    out_ready = 1'b0;
    do_reset(16'd7);
    send(2, 3); send(1, 1); send(0, 0); send(0, 0);
    send(9, 9); send(9, 9);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pend_valid", longint'(out_valid), 1);
    chk("pend_data", out_data, 14);
    reset = 1'b1;
    #1;
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_data", out_data, 0);
    bias = 16'd0;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    send(1, 2); send(1, 2); send(1, 2); send(1, 2);
    in_valid = 1'b0;
    wait_out(rd);
    chk("post_rst_data", rd, 8);

    // K=1: one vector every 3 cycles
    k1_valid = 1'b1;
    do_reset(16'd0);
    k1_cnt   = 0;
    k1_first = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (k1_out_valid) begin
        k1_cnt++;
        if (k1_first < 0) k1_first = n;
        chk("k1_data", k1_out_data, 23);
      end
    end
    chk("k1_count", k1_cnt, 4);
    chk("k1_first", k1_first, 3);
    k1_valid = 1'b0;

    // Random operands, bubbles and backpressure against the model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset(16'($urandom));
      for (int c = 0; c < 150; c++) begin
        in_valid  = ($urandom_range(3) != 0);
        in_a      = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
        in_b      = ($urandom_range(7) == 0) ? 16'h7FFF : 16'($urandom);
        out_ready = ($urandom_range(2) != 0);
        @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("rand_drain_empty", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
